// File: rtl/ext_mem_reader_cmd_gen.sv
// Splits a linear read request into 72-bit datamover read commands.
// Each command is capped at MaxBurstBytes and never crosses a
// BoundaryBytes-aligned address boundary. All outputs are registered.
module ext_mem_reader_cmd_gen #(
  parameter int MaxBurstBytes = 256,
  parameter int BoundaryBytes = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [22:0] req_bytes,
  output logic [71:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        busy
);

  localparam int          BW    = $clog2(BoundaryBytes);
  localparam logic [BW:0] BOUND = (BW+1)'(BoundaryBytes);
  localparam logic [31:0] MAX32 = 32'(MaxBurstBytes);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_cur_addr, w_cur_addr_next;
  logic [22:0] r_remaining, w_remaining_next;
  logic [3:0]  r_tag, w_tag_next;
  logic [71:0] r_cmd_data, w_cmd_data_next;
  logic        r_cmd_valid, w_cmd_valid_next;
  logic        r_req_ready, w_req_ready_next;
  logic        r_busy, w_busy_next;

  logic [BW:0] w_to_bound;
  logic [31:0] w_to_bound32;
  logic [22:0] w_chunk;
  logic [22:0] w_btt;
  logic        w_req_fire;
  logic        w_cmd_fire;

  assign w_req_fire = req_valid && r_req_ready;
  assign w_cmd_fire = r_cmd_valid && cmd_ready;
  // BTT of the command currently held for issue
  assign w_btt      = r_cmd_data[22:0];

  // Bytes left before the next boundary (full boundary when aligned)
  assign w_to_bound   = BOUND - {1'b0, r_cur_addr[BW-1:0]};
  assign w_to_bound32 = 32'(w_to_bound);

  // chunk = min(remaining, max burst, distance to boundary)
  always_comb begin
    w_chunk = r_remaining;
    if ({9'd0, w_chunk} > MAX32)        w_chunk = MAX32[22:0];
    if ({9'd0, w_chunk} > w_to_bound32) w_chunk = w_to_bound32[22:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_req_fire && (req_bytes != 23'd0)) w_state_next = CALC;
      CALC:    w_state_next = ISSUE;
      ISSUE:   if (w_cmd_fire) w_state_next = (r_remaining == w_btt) ? IDLE : CALC;
      default: w_state_next = IDLE;
    endcase
  end

  // Output and datapath next values, registered below
  always_comb begin
    w_cur_addr_next  = r_cur_addr;
    w_remaining_next = r_remaining;
    w_tag_next       = r_tag;
    w_cmd_data_next  = r_cmd_data;
    w_req_ready_next = (w_state_next == IDLE);
    w_busy_next      = (w_state_next != IDLE);
    w_cmd_valid_next = (w_state_next == ISSUE);
    case (r_state)
      IDLE: begin
        if (w_req_fire && (req_bytes != 23'd0)) begin
          w_cur_addr_next  = req_addr;
          w_remaining_next = req_bytes;
        end
      end
      CALC: begin
        w_cmd_data_next = {4'd0, r_tag, r_cur_addr, 1'b0,
                           (w_chunk == r_remaining), 6'd0, 1'b1, w_chunk};
      end
      ISSUE: begin
        if (w_cmd_fire) begin
          w_cur_addr_next  = r_cur_addr + 32'(w_btt);
          w_remaining_next = r_remaining - w_btt;
          w_tag_next       = r_tag + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath; reset abandons any partial request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr  <= 32'd0;
      r_remaining <= 23'd0;
      r_tag       <= 4'd0;
      r_cmd_data  <= 72'd0;
      r_cmd_valid <= 1'b0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cur_addr  <= w_cur_addr_next;
      r_remaining <= w_remaining_next;
      r_tag       <= w_tag_next;
      r_cmd_data  <= w_cmd_data_next;
      r_cmd_valid <= w_cmd_valid_next;
      r_req_ready <= w_req_ready_next;
      r_busy      <= w_busy_next;
    end
  end

  assign req_ready = r_req_ready;
  assign cmd_data  = r_cmd_data;
  assign cmd_valid = r_cmd_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ext_mem_reader_cmd_gen.sv
// Directed self-checking bench for ext_mem_reader_cmd_gen.
module tb_ext_mem_reader_cmd_gen;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [22:0] req_bytes;
  logic [71:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  ext_mem_reader_cmd_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_bytes (req_bytes),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] mk_cmd(input logic [31:0] addr, input logic [22:0] btt,
                                         input logic [3:0] tag, input logic eof);
    return {4'd0, tag, addr, 1'b0, eof, 6'd0, 1'b1, btt};
  endfunction

  // Present a request at negedge and hold it until accepted
  task automatic send_req(input logic [31:0] addr, input logic [22:0] bytes);
    int n;
    n = 0;
    req_addr  = addr;
    req_bytes = bytes;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout addr=%h req_ready=%b required 1", addr, req_ready);
    end else begin
      @(negedge clk);
    end
    req_valid = 1'b0;
    $display("REQ addr=%h bytes=%h", addr, bytes);
  endtask

  // Wait for a command, compare it, then complete one handshake
  task automatic expect_cmd(input logic [31:0] addr, input logic [22:0] btt,
                            input logic [3:0] tag, input logic eof, input string name);
    int n;
    logic [71:0] exp_cmd;
    n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout cmd_valid=%b required 1", name, cmd_valid);
      return;
    end
    exp_cmd = mk_cmd(addr, btt, tag, eof);
    checks++;
    if (cmd_data !== exp_cmd) begin
      failures++;
      $display("FAIL %s_data got=%h required=%h", name, cmd_data, exp_cmd);
    end
    $display("CMD %s saddr=%h btt=%h tag=%0d eof=%b", name, cmd_data[63:32],
             cmd_data[22:0], cmd_data[67:64], cmd_data[30]);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid_drop cmd_valid=%b required 0", name, cmd_valid);
    end
    checks++;
    if (busy !== !eof) begin
      failures++;
      $display("FAIL %s_busy busy=%b required %b", name, busy, !eof);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    req_bytes = 23'd0;
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, cmd_valid, busy} !== 3'b000 || cmd_data !== 72'd0) begin
      failures++;
      $display("FAIL reset_outputs rr=%b cv=%b busy=%b data=%h required 0", req_ready,
               cmd_valid, busy, cmd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
    $display("RESET released");
  endtask

  task automatic test_split();
    send_req(32'h0000_1000, 23'h300);
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL split_calc cv=%b busy=%b rr=%b required 0/1/0", cmd_valid, busy, req_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL split_latency cmd_valid=%b required 1", cmd_valid);
    end
    expect_cmd(32'h1000, 23'h100, 4'd0, 1'b0, "split0");
    expect_cmd(32'h1100, 23'h100, 4'd1, 1'b0, "split1");
    expect_cmd(32'h1200, 23'h100, 4'd2, 1'b1, "split2");
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL split_done req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_boundary();
    send_req(32'h0000_0FF0, 23'h40);
    expect_cmd(32'h0FF0, 23'h10, 4'd3, 1'b0, "bound0");
    expect_cmd(32'h1000, 23'h30, 4'd4, 1'b1, "bound1");
  endtask

  task automatic test_zero_len();
    bit seen;
    send_req(32'h0000_0000, 23'h0);
    seen = 1'b0;
    repeat (4) begin
      if (cmd_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL zero_len_activity cv=%b busy=%b required 0/0", cmd_valid, busy);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_len_ready req_ready=%b required 1", req_ready);
    end
    send_req(32'h0000_2000, 23'h105);
    expect_cmd(32'h2000, 23'h100, 4'd5, 1'b0, "tail0");
    expect_cmd(32'h2100, 23'h005, 4'd6, 1'b1, "tail1");
  endtask

  task automatic test_backpressure();
    int n;
    logic [71:0] exp_cmd;
    exp_cmd = mk_cmd(32'h3000, 23'h100, 4'd7, 1'b0);
    send_req(32'h0000_3000, 23'h180);
    n = 0;
    while (cmd_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd_data !== exp_cmd || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d cv=%b rr=%b data=%h required 1/0/%h", i, cmd_valid,
                 req_ready, cmd_data, exp_cmd);
      end
      @(negedge clk);
    end
    $display("BP held 5 cycles");
    expect_cmd(32'h3000, 23'h100, 4'd7, 1'b0, "bp0");
    expect_cmd(32'h3100, 23'h080, 4'd8, 1'b1, "bp1");
  endtask

  task automatic test_reset_mid();
    bit seen;
    send_req(32'h0000_0000, 23'h1000);
    expect_cmd(32'h0000, 23'h100, 4'd9, 1'b0, "rmid0");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, cmd_valid, busy} !== 3'b000 || cmd_data !== 72'd0) begin
      failures++;
      $display("FAIL rmid_async rr=%b cv=%b busy=%b data=%h required 0", req_ready,
               cmd_valid, busy, cmd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (cmd_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rmid_stale cmd activity after reset, required none");
    end
    send_req(32'h0000_4000, 23'h10);
    expect_cmd(32'h4000, 23'h10, 4'd0, 1'b1, "rmid_new");
  endtask

  task automatic test_tag_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      send_req(32'h0000_5000 + 32'(i * 16), 23'h10);
      expect_cmd(32'h0000_5000 + 32'(i * 16), 23'h10, 4'(i), 1'b1, "wrap");
    end
  endtask

  initial begin
    test_reset();
    test_split();
    test_boundary();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_tag_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_mem_reader_cmd_gen.md
Name: ext_mem_reader_cmd_gen

Overview:
Upstream command generator for the external-memory reader path. It accepts a linear read request (start address, total byte count) and splits it into 72-bit datamover-format read commands. Each command is limited to MaxBurstBytes and never crosses a BoundaryBytes-aligned boundary. The command stream feeds the reader command translator through a valid/ready handshake.

Parameters:
MaxBurstBytes, 256, maximum BTT per command; power of two, at least 4, and no greater than BoundaryBytes.
BoundaryBytes, 4096, address boundary that no command may cross; power of two.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_addr  input  32  request start byte address
req_bytes  input  23  request total byte count
cmd_data  output  72  datamover read command
cmd_valid  output  1  command valid
cmd_ready  input  1  downstream accepts command
busy  output  1  high while a request is being split

Behaviour:
- Reset: state=Idle; req_ready=0; cmd_valid=0; cmd_data=0; busy=0; tag counter=0; internal addr/remaining=0.
- Reset asserted mid-operation clears everything immediately. The partial request is abandoned and no further commands are issued.
- cmd_data field layout:
  - [22:0] BTT
  - [23] type = 1 (INCR)
  - [29:24] DSA = 0
  - [30] EOF = 1 only on the last command of a request
  - [31] DRR = 0
  - [63:32] SADDR
  - [67:64] TAG
  - [71:68] = 0
- States are Idle, Calc and Issue. All outputs are registered.
- Idle:
  - req_ready=1, busy=0.
  - On req_valid with req_bytes != 0: capture cur_addr=req_addr and remaining=req_bytes; go to Calc; req_ready=0 and busy=1 from the next cycle.
  - On req_valid with req_bytes == 0: the request is accepted and dropped. No command is issued and the state stays Idle.
- Calc (one cycle):
  - to_bound = BoundaryBytes - (cur_addr mod BoundaryBytes).
  - chunk = min(remaining, MaxBurstBytes, to_bound).
  - Load cmd_data with BTT=chunk, SADDR=cur_addr, TAG=tag counter, EOF=(chunk==remaining).
  - Set cmd_valid=1 and go to Issue.
- Issue:
  - cmd_valid stays high. cmd_data must be held stable until cmd_valid && cmd_ready.
  - On the handshake: cmd_valid=0, cur_addr += chunk, remaining -= chunk, tag counter += 1 (4-bit, wraps 15 to 0).
  - After the handshake, go to Idle if remaining becomes 0, else go to Calc.
- Latency: request handshake in cycle N gives cmd_valid high in cycle N+2. Back-to-back chunks issue at most one command every 2 cycles.
- Arithmetic widths:
  - cur_addr uses 32-bit arithmetic; wrap past 0xFFFFFFFF is allowed and not flagged.
  - remaining and chunk are 23 bits.
  - to_bound is computed at width log2(BoundaryBytes)+1.
- The tag counter persists across requests and is cleared only by reset.
- cmd_ready held high continuously is legal: one command completes per Issue cycle.
- cmd_ready asserted while cmd_valid=0 has no effect.

Test Plan:
- Split at burst limit: defaults, req 0x00001000/0x300 gives 3 cmds.
  - Cmds are (SADDR, BTT) = 0x1000/0x100, 0x1100/0x100, 0x1200/0x100.
  - TAG = 0, 1, 2; EOF only on the 3rd; busy falls after the 3rd handshake.
- Boundary crossing: req 0x00000FF0/0x40 gives cmds 0x0FF0/0x10 (EOF=0) then 0x1000/0x30 (EOF=1).
  - cmd_data[23]=1 on both; bits [71:68], [31] and [29:24] are 0.
- Zero length and unaligned tail:
  - req_bytes=0 is accepted with no cmd_valid and busy stays 0.
  - A following req 0x2000/0x105 gives 0x2000/0x100 then 0x2100/0x005 (EOF=1).
- Backpressure: hold cmd_ready=0 for 5 cycles while cmd_valid=1.
  - cmd_data stays unchanged and req_ready stays 0.
  - Raising cmd_ready completes exactly one handshake.
- Tag wrap: issue 17 single-chunk requests of 0x10 bytes; TAG sequence is 0..15 then 0.
- Reset mid-request: start req 0x0/0x1000, assert rst_n=0 after the first cmd handshake.
  - All outputs and the tag go to 0 asynchronously.
  - After release no stale cmd appears; the next request starts at TAG 0.
